// File: rtl/lsu_dmem.sv
// RV32 load/store unit: fixed-sequence single-port data-memory access, 4 transitions per load, 6 per store, 1 for an illegal request.
// Accepts only in IDLE; a response is held until resp_ready, with no same-cycle re-accept.
module lsu_dmem #(
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemdatain,
  output logic [2:0]  dmemop,
  output logic        dmemwe,
  output logic        dmemrdclk,
  output logic        dmemwrclk,
  input  logic [31:0] dmemdataout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RCLK  = 3'd2,
    RLOW  = 3'd3,
    WCLK  = 3'd4,
    WLOW  = 3'd5,
    RESP  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        st_q, st_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  op_q, op_d;
  logic        we_q, we_d;
  logic        rdclk_q, rdclk_d;
  logic        wrclk_q, wrclk_d;

  logic accept;
  logic is_half;
  logic is_word;
  logic bad_op;
  logic misaligned;
  logic illegal;

  assign accept  = req_valid && ready_q;
  assign is_half = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
  assign is_word = (req_funct3 == 3'b010);

  always_comb begin
    bad_op = 1'b0;
    if (req_we) begin
      bad_op = (req_funct3 > 3'b010);
    end else begin
      bad_op = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end
  end

  assign misaligned = MISALIGN_CHECK &&
                      ((is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00)));
  assign illegal    = bad_op || misaligned;

  // State plus every output is a flop, so the memory strobes are glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      st_q    <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      op_q    <= 3'd0;
      we_q    <= 1'b0;
      rdclk_q <= 1'b0;
      wrclk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      we_q    <= we_d;
      rdclk_q <= rdclk_d;
      wrclk_q <= wrclk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = illegal ? RESP : SETUP;
        end
      end
      SETUP:   state_d = RCLK;
      RCLK:    state_d = RLOW;
      RLOW:    state_d = st_q ? WCLK : RESP;
      WCLK:    state_d = WLOW;
      WLOW:    state_d = RESP;
      RESP: begin
        if (valid_q && resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    st_d    = accept ? req_we     : st_q;
    addr_d  = accept ? req_addr   : addr_q;
    wdata_d = accept ? req_wdata  : wdata_q;
    op_d    = accept ? req_funct3 : op_q;
    ready_d = (state_d == IDLE);
    valid_d = (state_d == RESP);
    rdclk_d = (state_d == RCLK);
    wrclk_d = (state_d == WCLK);
    we_d    = st_d && ((state_d == SETUP) || (state_d == RCLK) || (state_d == RLOW) ||
                       (state_d == WCLK) || (state_d == WLOW));
    err_d   = (state_d == RESP) && ((state_q == IDLE) || err_q);
    rdata_d = 32'd0;
    if (state_d == RESP) begin
      rdata_d = ((state_q == RLOW) && !st_q) ? dmemdataout : rdata_q;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign dmemaddr   = addr_q;
  assign dmemdatain = wdata_q;
  assign dmemop     = op_q;
  assign dmemwe     = we_q;
  assign dmemrdclk  = rdclk_q;
  assign dmemwrclk  = wrclk_q;

endmodule
